// File: rtl/snic_rate_meter.sv
// Per-window AXI4-Stream traffic meter: counts accepted bytes/packets between ticks and
// publishes a sequence-tagged snapshot on a registered valid/ready port, counting lost snapshots.
module snic_rate_meter #(
  parameter int unsigned DATA_BYTES = 64,
  parameter int unsigned CNT_W      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  input  logic [DATA_BYTES-1:0] mon_tkeep,
  output logic                  rate_valid,
  input  logic                  rate_ready,
  output logic [CNT_W-1:0]      rate_pkts,
  output logic [CNT_W-1:0]      rate_bytes,
  output logic [15:0]           rate_seq,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned KeepCntW = $clog2(DATA_BYTES + 1);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     pkt_acc_q, pkt_acc_d;
  logic [CNT_W-1:0]     byte_acc_q, byte_acc_d;
  logic [CNT_W-1:0]     pkts_q, bytes_q;
  logic [15:0]          seq_ctr_q, seq_q, drop_q;
  logic [KeepCntW-1:0]  keep_cnt;
  logic                 beat_ok;
  logic [CNT_W-1:0]     beat_bytes;
  logic [CNT_W-1:0]     beat_pkt;
  logic [CNT_W-1:0]     pkt_sum, byte_sum;
  logic                 load_snap;
  logic                 drop_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Byte lanes counted individually so sparse keep patterns are measured exactly.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      keep_cnt = keep_cnt + KeepCntW'(mon_tkeep[i]);
    end
  end

  assign beat_ok    = mon_tvalid & mon_tready;
  assign beat_bytes = beat_ok ? CNT_W'(keep_cnt) : '0;
  assign beat_pkt   = CNT_W'(beat_ok & mon_tlast);
  assign pkt_sum    = sat_add(pkt_acc_q, beat_pkt);
  assign byte_sum   = sat_add(byte_acc_q, beat_bytes);

  // The tick-cycle beat belongs to the closing window, so the snapshot takes the sums.
  always_comb begin
    pkt_acc_d  = pkt_sum;
    byte_acc_d = byte_sum;
    if (tick) begin
      pkt_acc_d  = '0;
      byte_acc_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_snap = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (tick) begin
          load_snap = 1'b1;
          state_d   = StFull;
        end
      end
      StFull: begin
        if (tick) begin
          load_snap = 1'b1;
          drop_inc  = ~rate_ready;
        end else if (rate_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      pkt_acc_q  <= '0;
      byte_acc_q <= '0;
      pkts_q     <= '0;
      bytes_q    <= '0;
      seq_q      <= '0;
      seq_ctr_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pkt_acc_q  <= pkt_acc_d;
      byte_acc_q <= byte_acc_d;
      if (load_snap) begin
        pkts_q  <= pkt_sum;
        bytes_q <= byte_sum;
        seq_q   <= seq_ctr_q;
      end
      if (tick) begin
        seq_ctr_q <= seq_ctr_q + 16'd1;
      end
      if (drop_inc && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign rate_valid = (state_q == StFull);
  assign rate_pkts  = pkts_q;
  assign rate_bytes = bytes_q;
  assign rate_seq   = seq_q;
  assign drop_cnt   = drop_q;

endmodule

// File: doc/snic_rate_meter.md
# snic_rate_meter

Per-window traffic meter in the shell's monitoring path. It sits directly downstream of the periodic timeout-pulse timer, which drives `tick`. It passively taps an AXI4-Stream interface and counts accepted bytes and packets between consecutive ticks. At each tick it publishes a snapshot of the closed window through a valid/ready result port, tags it with a sequence number, and counts snapshots that are lost because the consumer was slow.

## Interface
- `DATA_BYTES`, default 64: byte lanes on the tapped stream (`mon_tkeep` width).
- `CNT_W`, default 48: width of the packet and byte accumulators and snapshots. Must satisfy `CNT_W >= $clog2(DATA_BYTES+1)`.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle window-close pulse from the timer.
- `mon_tvalid`  in  1  tapped stream valid.
- `mon_tready`  in  1  tapped stream ready. Observed only; this block never drives it.
- `mon_tlast`  in  1  tapped stream last.
- `mon_tkeep`  in  DATA_BYTES  tapped stream byte enables.
- `rate_valid`  out  1  snapshot available.
- `rate_ready`  in  1  consumer accepts snapshot.
- `rate_pkts`  out  CNT_W  packets completed in the closed window.
- `rate_bytes`  out  CNT_W  bytes accepted in the closed window.
- `rate_seq`  out  16  window sequence number. Wraps 0xFFFF -> 0x0000.
- `drop_cnt`  out  16  snapshots overwritten before being consumed. Saturates at 0xFFFF.

## Operation
- Beat accepted: `mon_tvalid & mon_tready`. Non-accepted cycles contribute nothing.
- Bytes per beat = popcount(`mon_tkeep`), 0..DATA_BYTES. Non-contiguous keep is counted bit by bit.
- A packet is counted on an accepted beat with `mon_tlast=1`.
- Accumulators `pkt_acc` and `byte_acc` are CNT_W wide and saturate at all-ones; they never wrap.
- Tick cycle:
  - The snapshot equals the accumulator value plus that cycle's accepted beat, saturated. The closing window owns the tick-cycle beat.
  - Accumulators load 0.
  - `seq_ctr` is copied to `rate_seq`, then `seq_ctr` increments.
- Output register, two states:
  - EMPTY (`rate_valid=0`): a tick loads the snapshot and moves to FULL.
  - FULL (`rate_valid=1`): outputs are held stable until the handshake `rate_valid & rate_ready`.
    - Handshake, no tick: go to EMPTY.
    - Handshake and tick in the same cycle: the old snapshot is consumed, the new one loads, stay FULL, no drop.
    - Tick without `rate_ready`: the new snapshot overwrites, stay FULL, `drop_cnt` +1 (saturating). `rate_seq` gap reveals the loss.
- `tick` asserted on consecutive cycles: each cycle is a separate window. A window with no traffic produces zero counts.

## Timing
- Reset values: `rate_valid=0`, `rate_pkts=0`, `rate_bytes=0`, `rate_seq=0`, `drop_cnt=0`, accumulators 0, `seq_ctr=0`.
- Reset asserted mid-window or while FULL clears everything immediately, without waiting for `clk`. The first tick after reset yields `rate_seq=0`.
- Latency: snapshot outputs and `rate_valid` update on the clock edge ending the tick cycle, so they are visible in cycle T+1.
- Accumulator update on accepted beats takes effect on the next edge. Popcount may be combinational; the result port is fully registered.
- Output changes only on a tick or on a handshake. `rate_*` must not change while `rate_valid=1 & rate_ready=0`, except on a tick overwrite.
- No combinational path from `rate_ready` to any output.

## Test plan
- Reset, then 3 accepted full beats (keep all-ones, DATA_BYTES=64), last on beat 3, then tick with `rate_ready=1` -> cycle T+1: `rate_valid=1`, pkts=1, bytes=192, seq=0; `rate_valid=0` one cycle later.
- Accepted beat with `tkeep=0x...0F`, `tlast=1` in the same cycle as tick, then beat keep=0xFF, `tlast=1` next cycle, then tick -> snapshot0 bytes=4, pkts=1; snapshot1 bytes=8, pkts=1. Beats with `tvalid=1, tready=0` add 0.
- Hold `rate_ready=0` across 3 ticks -> `drop_cnt=2`, outputs show seq=2. Raise `rate_ready` -> `rate_valid` falls next cycle. Then handshake coincident with tick -> no drop, seq=3 loaded.
- CNT_W=8, 300 single-lane tlast beats in one window -> pkts=255 and bytes=255 (saturated). The next window restarts from 0.
- 65537 ticks with `rate_ready=1` -> `rate_seq` wraps to 0 on the 65537th snapshot. With `rate_ready=0`, `drop_cnt` holds at 0xFFFF.
- Async `rst` pulsed between clock edges while FULL with nonzero accumulators -> all outputs 0 before the next edge; the next tick gives seq=0 with counts only from post-reset traffic.
